// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single shared memory port
//
// Purpose: shares one memory port between instruction fetch (IF) and the
// load/store unit (LSU). LSU has priority; a starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive LSU grants while fetch is waiting.
//
// Parameters:
//   STARVE_LIMIT   - consecutive LSU grants allowed while a fetch waits
//   TIMEOUT_CYCLES - busy cycles without mem_ack before abort (timeout builds only)
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN (builds the busy-cycle timeout;
// when undefined the port waits for mem_ack indefinitely and bus_err is 0).
//
// Ports:
//   clk, rst                      - clock (rising edge), async active-high reset
//   if_req, if_addr               - fetch request and word address
//   if_gnt, if_rvalid, if_rdata   - fetch grant pulse, data valid pulse, data
//   ls_req, ls_we, ls_addr,
//   ls_wdata, ls_be               - LSU request, write flag, address, data, byte enables
//   ls_gnt, ls_rvalid, ls_rdata   - LSU grant pulse, completion pulse, load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be             - shared memory port request (registered)
//   mem_ack, mem_rdata            - memory completion and read data
//   stall_fetch, stall_mem        - pipeline freeze while a request is outstanding
//   bus_err                       - one-cycle timeout flag

module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          fetch_wins;

  // Fetch only beats a concurrent LSU request once it has been starved.
  assign fetch_wins  = if_req & (~ls_req | (starve_cnt == STARVE_MAX));

  assign stall_fetch = if_req & ~if_rvalid;
  assign stall_mem   = ls_req & ~ls_rvalid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] busy_cnt;
`else
  // TIMEOUT_CYCLES only matters when the timeout logic is built.
  assign bus_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_gnt     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      busy_cnt   <= '0;
      bus_err    <= 1'b0;
`endif
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err   <= 1'b0;
`endif

      // Starve counter only tracks LSU wins while a fetch is actually waiting.
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (state == IDLE) begin
        if (fetch_wins)
          starve_cnt <= '0;
        else if (ls_req && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + SW'(1);
      end

      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            mem_req <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt <= '0;
`endif
            if (fetch_wins) begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= 4'hF;
              if_gnt    <= 1'b1;
              state     <= BUSY_IF;
            end else begin
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_be    <= ls_be;
              ls_gnt    <= 1'b1;
              state     <= BUSY_LS;
            end
          end
        end

        BUSY_IF, BUSY_LS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_IF) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              ls_rdata  <= mem_we ? 32'd0 : mem_rdata;
              ls_rvalid <= 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (busy_cnt == BUSY_LAST) begin
            // Abort: complete the owner with zero data and flag the error.
            mem_req <= 1'b0;
            state   <= IDLE;
            bus_err <= 1'b1;
            if (state == BUSY_IF) begin
              if_rdata  <= '0;
              if_rvalid <= 1'b1;
            end else begin
              ls_rdata  <= '0;
              ls_rvalid <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + TW'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while a fetch request waits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: busy cycles without mem_ack before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be:
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 if_req  in  1  fetch request; if_addr  in  32  word-aligned fetch address.
REQ-007 if_gnt  out  1  fetch grant pulse; if_rvalid  out  1  fetch data valid; if_rdata  out  32  fetch data.
REQ-008 ls_req  in  1  LSU request from the MEMPREP stage; ls_we  in  1  write; ls_addr  in  32; ls_wdata  in  32; ls_be  in  4  byte enables.
REQ-009 ls_gnt  out  1  LSU grant pulse; ls_rvalid  out  1  LSU completion; ls_rdata  out  32  load data.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4: single shared memory port.
REQ-011 mem_ack  in  1  transfer complete; mem_rdata  in  32  read data, valid with mem_ack.
REQ-012 stall_fetch  out  1; stall_mem  out  1  freeze the IF stage and the MEMPREP/MEMEX pipeline register.
REQ-013 bus_err  out  1  one-cycle timeout flag.

Function
REQ-014 FSM states IDLE, BUSY_IF and BUSY_LS.
REQ-015 In IDLE at a rising edge with any request: latch the winner's address, data, byte enables and write flag into the mem_* registers; set mem_req=1; pulse the winner's gnt for exactly one cycle; enter BUSY_IF or BUSY_LS.
REQ-016 Arbitration priority: LSU wins over fetch, except that fetch wins when the starve counter equals STARVE_LIMIT and if_req=1.
REQ-017 Starve counter: increments on each LSU grant while if_req=1; clears on a fetch grant or whenever if_req=0; saturates at STARVE_LIMIT.
REQ-018 In BUSY_x: mem_* outputs hold stable and mem_req stays 1 until mem_ack=1.
REQ-019 On the mem_ack edge: register mem_rdata into the owner's rdata and pulse the owner's rvalid for one cycle (latency = 1 cycle after ack); drop mem_req; return to IDLE.
REQ-020 A write completion pulses ls_rvalid with ls_rdata=0.
REQ-021 Earliest next grant is the edge after completion, so minimum spacing between grants is 2 cycles; the other requester's pending request wins if eligible.
REQ-022 mem_ack in IDLE SHALL be ignored.
REQ-023 rdata holds its last value between rvalid pulses.
REQ-024 stall_fetch = if_req & ~if_rvalid; stall_mem = ls_req & ~ls_rvalid (combinational).
REQ-025 A request deasserted before grant SHALL be dropped without any memory access.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, all gnt/rvalid=0, rdata=0, bus_err=0, starve and timeout counters=0.
REQ-027 Reset during BUSY aborts the transfer with no rvalid; a mem_ack arriving after reset release SHALL be ignored.

Configuration
REQ-028 Macro MEM_ARB_TIMEOUT_EN defined: a busy-cycle counter runs in BUSY_x; on reaching TIMEOUT_CYCLES without ack, the block drops mem_req, pulses the owner's rvalid with rdata=0, pulses bus_err, and returns to IDLE.
REQ-029 Macro MEM_ARB_TIMEOUT_EN undefined: no counter is built, BUSY_x waits indefinitely, and bus_err is tied 0.

Verification
REQ-030 Single fetch: if_req, if_addr=0x100; mem_ack with rdata=0xDEADBEEF 3 cycles after mem_req -> if_gnt for 1 cycle; if_rvalid and if_rdata=0xDEADBEEF one cycle after ack.
REQ-031 Simultaneous requests: if_req and ls_req (load 0x2000) in the same cycle -> LSU granted first; fetch granted at the edge after ls_rvalid.
REQ-032 Starvation: if_req held high, LSU requests back-to-back -> after 4 LSU grants the next grant goes to fetch.
REQ-033 Store: ls_we=1, ls_be=0b0011, ls_wdata=0x1234 -> mem_* match the request and are stable until ack; ls_rvalid with ls_rdata=0; stall_mem low after completion.
REQ-034 Reset mid-transfer: rst during BUSY_LS -> mem_req=0 immediately; no ls_rvalid; a late mem_ack is ignored.
REQ-035 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> after 8 busy cycles bus_err and ls_rvalid pulse with rdata=0; state returns to IDLE.
